// File: rtl/mcycle_issuer.sv
// mcycle_issuer: Execute-stage requester for the multi-cycle mul/div unit.
// Ports: CLK/RESET; req_valid/req_funct3/req_rs1/req_rs2/kill from the
// pipeline; stall/result/result_valid back to it; mc_start/mc_op/mc_op1/
// mc_op2 to the unit, mc_result1/mc_result2/mc_busy from it.
// Option: MCYCLE_RESULT_REUSE_EN caches the last completed unit transaction.
module mcycle_issuer #(
  parameter int width = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             req_valid,
  input  logic [2:0]       req_funct3,
  input  logic [width-1:0] req_rs1,
  input  logic [width-1:0] req_rs2,
  input  logic             kill,
  output logic             stall,
  output logic [width-1:0] result,
  output logic             result_valid,
  output logic             mc_start,
  output logic [1:0]       mc_op,
  output logic [width-1:0] mc_op1,
  output logic [width-1:0] mc_op2,
  input  logic [width-1:0] mc_result1,
  input  logic [width-1:0] mc_result2,
  input  logic             mc_busy
);

  localparam logic [width-1:0] SMIN =
    {1'b1, {(width-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, DRAIN, DONE
  } state_t;

  state_t     state;
  logic [2:0] f3_q;
  logic       rv_q;

  function automatic logic [1:0] op_of(
    input logic [2:0] f
  );
    logic [1:0] o;
    unique case (f)
      3'b001:         o = 2'b00;
      3'b100, 3'b110: o = 2'b10;
      3'b101, 3'b111: o = 2'b11;
      default:        o = 2'b01;
    endcase
    return o;
  endfunction

  // MULHSU runs as an unsigned multiply; a negative rs1 was
  // treated as rs1 + 2^32, so rs2 is taken back off the MSW.
  function automatic logic [width-1:0] pick(
    input logic [2:0]       f,
    input logic [width-1:0] a,
    input logic [width-1:0] b,
    input logic [width-1:0] r1,
    input logic [width-1:0] r2
  );
    logic [width-1:0] r;
    unique case (1'b1)
      (f == 3'b000),
      (f[2:1] == 2'b10): r = r1;
      (f == 3'b010):
        r = r2 - (a[width-1] ? b : '0);
      default:           r = r2;
    endcase
    return r;
  endfunction

  logic             dz;
  logic             ovf;
  logic             special;
  logic             hit;
  logic [1:0]       req_op;
  logic [width-1:0] spec_res;
  logic [width-1:0] hit_res;

  always_comb begin
    req_op  = op_of(req_funct3);
    dz      = req_funct3[2] & (req_rs2 == '0);
    ovf     = req_funct3[2] & ~req_funct3[0] &
              (req_rs1 == SMIN) & (req_rs2 == '1);
    special = dz | ovf;
    if (dz)
      spec_res = req_funct3[1] ? req_rs1 : '1;
    else
      spec_res = req_funct3[1] ? '0 : SMIN;
  end

`ifdef MCYCLE_RESULT_REUSE_EN
  logic             c_vld;
  logic [1:0]       c_op;
  logic [width-1:0] c_a;
  logic [width-1:0] c_b;
  logic [width-1:0] c_r1;
  logic [width-1:0] c_r2;

  assign hit = c_vld & (c_op == req_op) &
               (c_a == req_rs1) & (c_b == req_rs2);
  assign hit_res = pick(req_funct3, req_rs1,
                        req_rs2, c_r1, c_r2);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      c_vld <= 1'b0;
      c_op  <= '0;
      c_a   <= '0;
      c_b   <= '0;
      c_r1  <= '0;
      c_r2  <= '0;
    end else if (kill &&
                 (state == ISSUE || state == WAIT)) begin
      c_vld <= 1'b0;
    end else if (state == WAIT && !mc_busy) begin
      c_vld <= 1'b1;
      c_op  <= mc_op;
      c_a   <= mc_op1;
      c_b   <= mc_op2;
      c_r1  <= mc_result1;
      c_r2  <= mc_result2;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      f3_q     <= '0;
      rv_q     <= 1'b0;
      result   <= '0;
      mc_start <= 1'b0;
      mc_op    <= '0;
      mc_op1   <= '0;
      mc_op2   <= '0;
    end else begin
      mc_start <= 1'b0;
      rv_q     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid && !kill) begin
            f3_q <= req_funct3;
            if (special) begin
              result <= spec_res;
              rv_q   <= 1'b1;
              state  <= DONE;
            end else if (hit) begin
              result <= hit_res;
              rv_q   <= 1'b1;
              state  <= DONE;
            end else begin
              mc_op    <= req_op;
              mc_op1   <= req_rs1;
              mc_op2   <= req_rs2;
              mc_start <= 1'b1;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: state <= kill ? DRAIN : WAIT;
        WAIT: begin
          if (kill) begin
            state <= DRAIN;
          end else if (!mc_busy) begin
            result <= pick(f3_q, mc_op1, mc_op2,
                           mc_result1, mc_result2);
            rv_q   <= 1'b1;
            state  <= DONE;
          end
        end
        // The unit cannot be aborted; let it finish.
        DRAIN: if (!mc_busy) state <= IDLE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign result_valid = rv_q & ~kill;
  assign stall = req_valid & ~kill & (state != DONE);

endmodule

// File: doc/mcycle_issuer.md
# mcycle_issuer

Pipeline-side requester for the multi-cycle multiply/divide unit (`MCycle`). It sits in the Execute stage and accepts RV32M requests (funct3 plus two operands). It drives the unit's Start/MCycleOp/Operand lines, holds the pipeline stalled while the unit is Busy, and selects the architectural 32-bit result. It also resolves the RISC-V divide special cases (divide-by-zero, signed overflow) and MULHSU locally, without the unit needing to support them.

## Interface
Parameters:
- `width`, 32: operand/result width; only 32 is supported.

Ports:
- `CLK`  in  1  single clock.
- `RESET`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  M-instruction present in Execute; held high while `stall` is high.
- `req_funct3`  in  3  RV32M funct3 (000 MUL … 111 REMU).
- `req_rs1`, `req_rs2`  in  32  operand values.
- `kill`  in  1  flush; abandons the current request.
- `stall`  out  1  combinational; freezes the pipeline.
- `result`  out  32  architectural result; valid when `result_valid` is high.
- `result_valid`  out  1  one-cycle pulse; the pipeline advances on this edge.
- `mc_start`  out  1  Start to the unit.
- `mc_op`  out  2  MCycleOp: 00 mul signed, 01 mul unsigned, 10 div signed, 11 div unsigned.
- `mc_op1`, `mc_op2`  out  32  Operand1/Operand2 to the unit.
- `mc_result1`, `mc_result2`  in  32  LSW/quotient and MSW/remainder.
- `mc_busy`  in  1  Busy from the unit.

## Operation
States: IDLE, ISSUE, WAIT, DRAIN, DONE.

- **IDLE**, on `req_valid & ~kill`:
  - Latch funct3 and operands.
  - Special-case checks:
    - DIV/DIVU/REM/REMU with rs2 == 0 → DONE. Quotient = 0xFFFFFFFF; remainder = rs1.
    - DIV/REM with rs1 == 0x80000000 and rs2 == 0xFFFFFFFF → DONE. Quotient = 0x80000000; remainder = 0.
  - Otherwise → ISSUE.
- **ISSUE**: `mc_start` = 1 for exactly one cycle. `mc_op` and `mc_op1`/`mc_op2` are taken from registers and stay stable until the transaction ends. → WAIT.
- **WAIT**: on `mc_busy` == 0, capture the result and → DONE.
- **DONE**: `result_valid` = 1, `stall` = 0 → IDLE.
- **DRAIN**: on `mc_busy` == 0 → IDLE. Unit results are discarded.

Op mapping:
- MUL: mc_op 01, result1.
- MULH: 00, result2.
- MULHU: 01, result2.
- MULHSU: 01, result2 − (rs1[31] ? rs2 : 0), mod 2^32.
- DIV: 10, result1. DIVU: 11, result1.
- REM: 10, result2. REMU: 11, result2.

`stall` = `req_valid` & ~`kill` & (state != DONE).

Kill handling:
- `kill` in ISSUE or WAIT → DRAIN. The unit cannot be aborted.
- `kill` in IDLE or DONE → IDLE, with no `result_valid`.
- A `req_valid` that arrives while in DRAIN is stalled until DRAIN exits to IDLE.

Reset values: state IDLE; `mc_start` 0; `mc_op` 00; `mc_op1`/`mc_op2` 0; `result` 0; `result_valid` 0; reuse cache invalid. `RESET` asserted mid-operation returns to IDLE immediately. The unit is reset on the same `RESET`.

## Timing
- Special case: request in cycle N → `result_valid` in cycle N+1. `stall` is high in cycle N only.
- Normal path:
  - ISSUE at N+1.
  - `mc_busy` is high from N+1 through the unit's final cycle B.
  - DONE at B+2.
  - Total `stall` = B−N+2 cycles.
- `mc_result1`/`mc_result2` are sampled only in the WAIT cycle where `mc_busy` == 0.
- Back-to-back: the pipeline advances at DONE, so a new request can be accepted in IDLE on the following cycle. There is no overlap.

## Configuration
- `MCYCLE_RESULT_REUSE_EN` defined:
  - A cache holds the last completed unit transaction: `mc_op`, operands, result1, result2.
  - On a hit (same mc_op and same rs1/rs2; MULHSU is keyed as mc_op 01), IDLE → DONE directly with 1-cycle latency. Example: DIV followed by REM.
  - The cache is invalidated by RESET and by a kill/DRAIN.
  - Special-case results are never cached.
- `MCYCLE_RESULT_REUSE_EN` undefined: no cache; every non-special request goes through ISSUE/WAIT.

## Test plan
- MUL rs1 = 0xFFFFFFFE, rs2 = 3 → mc_op 01, `result` 0xFFFFFFFA; exactly one `mc_start` pulse.
- MULHSU rs1 = 0xFFFFFFFF, rs2 = 2 → `result` 0xFFFFFFFF. MULH with the same operands → 0xFFFFFFFF. MULHU with the same operands → 0x00000001.
- DIV rs1 = 0x80000000, rs2 = 0xFFFFFFFF → `result` 0x80000000 one cycle after the request; `mc_start` never asserted. REM with the same operands → 0.
- DIVU rs1 = 7, rs2 = 0 → 0xFFFFFFFF; REMU → 7; both 1-cycle.
- DIV rs1 = −7, rs2 = 2 → −3 (0xFFFFFFFD). REM with the same operands → −1, and with the macro defined this is a 1-cycle cache hit.
- `kill` asserted in WAIT → no `result_valid`. A new request arriving before `mc_busy` falls is stalled, then issued cleanly with correct data. `RESET` mid-WAIT → all outputs return to their reset values.
